// File: rtl/gray_updown_counter.sv
// gray_updown_counter: up/down counter with registered binary and Gray outputs.
// Features: modulo limit MAX_COUNT, wrap or saturate at bounds, and a
// synchronous load of a Gray-coded value that is clamped to MAX_COUNT.
// Optional build macro GRAY_CHECK_EN adds a sticky Gray single-step checker.
// Without the macro, gray_err is tied to 0 and the port list is unchanged.
module gray_updown_counter #(
  parameter int DATA_WIDTH = 4,
  parameter int MAX_COUNT  = (1 << DATA_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cnt_en,
  input  logic                  up_dn,
  input  logic                  sat_mode,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] load_gray,
  output logic [DATA_WIDTH-1:0] binary_out,
  output logic [DATA_WIDTH-1:0] gray_out,
  output logic                  wrap_pulse,
  output logic                  sat_flag,
  output logic                  load_err,
  output logic                  gray_err
);

  localparam logic [DATA_WIDTH-1:0] MAX_C = DATA_WIDTH'(MAX_COUNT);
  localparam bit FULL_RANGE = (MAX_COUNT == (1 << DATA_WIDTH) - 1);

  if (DATA_WIDTH < 2 || MAX_COUNT < 1 || MAX_COUNT > (1 << DATA_WIDTH) - 1) begin : g_bad_param
    $error("gray_updown_counter: DATA_WIDTH must be >= 2 and MAX_COUNT in 1..2**DATA_WIDTH-1");
  end

  logic [DATA_WIDTH-1:0] ld_bin;
  logic [DATA_WIDTH-1:0] bin_nxt;
  logic [DATA_WIDTH-1:0] gray_nxt;
  logic                  wrap_nxt;
  logic                  sat_nxt;
  logic                  lerr_nxt;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    ld_bin = '0;
    for (int i = 0; i < DATA_WIDTH; i++) ld_bin[i] = ^(load_gray >> i);
  end

  // Next count and flags; priority is load, then count step, then hold
  always_comb begin
    bin_nxt  = binary_out;
    wrap_nxt = 1'b0;
    sat_nxt  = 1'b0;
    lerr_nxt = 1'b0;
    if (load_en) begin
      if (ld_bin > MAX_C) begin
        bin_nxt  = MAX_C;
        lerr_nxt = 1'b1;
      end else begin
        bin_nxt = ld_bin;
      end
    end else if (cnt_en) begin
      if (up_dn) begin
        if (binary_out < MAX_C) bin_nxt = binary_out + 1'b1;
        else if (sat_mode)      sat_nxt = 1'b1;
        else begin
          bin_nxt  = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (binary_out != '0)   bin_nxt = binary_out - 1'b1;
        else if (sat_mode)      sat_nxt = 1'b1;
        else begin
          bin_nxt  = MAX_C;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  assign gray_nxt = bin_nxt ^ (bin_nxt >> 1);

  // Binary and Gray registers update on the same edge so they never disagree
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      binary_out <= '0;
      gray_out   <= '0;
      wrap_pulse <= 1'b0;
      sat_flag   <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      binary_out <= bin_nxt;
      gray_out   <= gray_nxt;
      wrap_pulse <= wrap_nxt;
      sat_flag   <= sat_nxt;
      load_err   <= lerr_nxt;
    end
  end

`ifdef GRAY_CHECK_EN
  logic [DATA_WIDTH-1:0] gdiff;
  logic                  adjacent;
  logic                  chk_step;

  // Saturate holds and short-range wraps are legitimately non-adjacent
  assign gdiff    = gray_nxt ^ gray_out;
  assign adjacent = (gdiff != '0) && ((gdiff & (gdiff - 1'b1)) == '0);
  assign chk_step = cnt_en && !load_en && !sat_nxt && (FULL_RANGE || !wrap_nxt);

  // Sticky single-bit-change checker on every count step
  always_ff @(posedge clk) begin
    if (!rst_n)                     gray_err <= 1'b0;
    else if (chk_step && !adjacent) gray_err <= 1'b1;
  end
`else
  assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: two instances (full range and MAX_COUNT=9)
// share stimulus; an arithmetic model is checked against both every cycle.
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, cnt_en = 1'b0, up_dn = 1'b0, sat_mode = 1'b0, load_en = 1'b0;
  logic [3:0] load_gray = '0;
  logic [3:0] b0, g0, b1, g1;
  logic       w0, s0, l0, e0, w1, s1, l1, e1;

  gray_updown_counter #(.DATA_WIDTH(4), .MAX_COUNT(15)) u0 (
    .clk(clk), .rst_n(rst_n), .cnt_en(cnt_en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load_en(load_en), .load_gray(load_gray), .binary_out(b0), .gray_out(g0),
    .wrap_pulse(w0), .sat_flag(s0), .load_err(l0), .gray_err(e0));

  gray_updown_counter #(.DATA_WIDTH(4), .MAX_COUNT(9)) u1 (
    .clk(clk), .rst_n(rst_n), .cnt_en(cnt_en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load_en(load_en), .load_gray(load_gray), .binary_out(b1), .gray_out(g1),
    .wrap_pulse(w1), .sat_flag(s1), .load_err(l1), .gray_err(e1));

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    bit wrap, sat, lerr, gerr;
  } ms_t;

  ms_t m0, m1;
  bit  force_g0 = 1'b0;
  int  n_cmp = 0, n_bad = 0;

  // Reference: plain integer arithmetic; Gray decode by table search
  function automatic ms_t mstep(ms_t s, int maxc);
    ms_t n = s;
    n.wrap = 1'b0; n.sat = 1'b0; n.lerr = 1'b0;
    if (!rst_n) begin
      n.bin = 0; n.gerr = 1'b0;
    end else if (load_en) begin
      int v = 0;
      for (int b = 0; b < 16; b++) if ((b ^ (b >> 1)) == int'(load_gray)) v = b;
      if (v > maxc) begin n.bin = maxc; n.lerr = 1'b1; end
      else n.bin = v;
    end else if (cnt_en) begin
      if (up_dn) begin
        if (s.bin < maxc) n.bin = s.bin + 1;
        else if (sat_mode) n.sat = 1'b1;
        else begin n.bin = 0; n.wrap = 1'b1; end
      end else begin
        if (s.bin > 0) n.bin = s.bin - 1;
        else if (sat_mode) n.sat = 1'b1;
        else begin n.bin = maxc; n.wrap = 1'b1; end
      end
    end
    return n;
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m0 = mstep(m0, 15);
    m1 = mstep(m1, 9);
    if (force_g0 && rst_n) begin m0.gerr = 1'b1; force_g0 = 1'b0; end
  end

  // Per-cycle compare of both instances against the model
  always @(negedge clk) begin
    cmp("u0.binary_out", 32'(b0), 32'(m0.bin));
    cmp("u0.gray_out",   32'(g0), 32'(m0.bin ^ (m0.bin >> 1)));
    cmp("u0.wrap_pulse", 32'(w0), 32'(m0.wrap));
    cmp("u0.sat_flag",   32'(s0), 32'(m0.sat));
    cmp("u0.load_err",   32'(l0), 32'(m0.lerr));
    cmp("u0.gray_err",   32'(e0), 32'(m0.gerr));
    cmp("u1.binary_out", 32'(b1), 32'(m1.bin));
    cmp("u1.gray_out",   32'(g1), 32'(m1.bin ^ (m1.bin >> 1)));
    cmp("u1.wrap_pulse", 32'(w1), 32'(m1.wrap));
    cmp("u1.sat_flag",   32'(s1), 32'(m1.sat));
    cmp("u1.load_err",   32'(l1), 32'(m1.lerr));
    cmp("u1.gray_err",   32'(e1), 32'(m1.gerr));
  end

  // Apply inputs after a falling edge; outputs are valid at the next falling edge
  task automatic step(bit r, bit l, bit e, bit u, bit s, logic [3:0] g);
    rst_n = r; load_en = l; cnt_en = e; up_dn = u; sat_mode = s; load_gray = g;
    @(negedge clk);
  endtask

  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    step(0, 0, 0, 0, 0, 4'd0);
    step(0, 0, 1, 1, 0, 4'd0);
    cmp("lit reset bin", 32'(b0), 32'd0);
    cmp("lit reset gray", 32'(g0), 32'd0);

    // Up count, wrap mode
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 1, 1, 0, 4'd0);
      if (i == 3)  cmp("lit up gray@3", 32'(g0), 32'd2);
      if (i == 15) begin cmp("lit up bin@15", 32'(b0), 32'd15); cmp("lit up gray@15", 32'(g0), 32'd8); end
      if (i == 16) begin cmp("lit wrap bin", 32'(b0), 32'd0); cmp("lit wrap pulse", 32'(w0), 32'd1); end
      if (i == 17) cmp("lit wrap pulse clr", 32'(w0), 32'd0);
      if (i == 9)  cmp("lit m9 bin@9", 32'(b1), 32'd9);
      if (i == 10) begin cmp("lit m9 wrap bin", 32'(b1), 32'd0); cmp("lit m9 wrap pulse", 32'(w1), 32'd1); end
    end
    cmp("lit gray_err quiet", 32'(e0), 32'd0);

    // Down from 0, wrap mode
    step(0, 0, 0, 0, 0, 4'd0);
    step(1, 0, 1, 0, 0, 4'd0);
    cmp("lit down wrap bin", 32'(b0), 32'd15);
    cmp("lit down wrap gray", 32'(g0), 32'd8);
    cmp("lit down wrap pulse", 32'(w0), 32'd1);
    cmp("lit m9 down wrap bin", 32'(b1), 32'd9);

    // Down from 0, saturate mode
    step(0, 0, 0, 0, 0, 4'd0);
    step(1, 0, 1, 0, 1, 4'd0);
    cmp("lit sat bin", 32'(b0), 32'd0);
    cmp("lit sat flag", 32'(s0), 32'd1);
    step(1, 0, 1, 0, 1, 4'd0);
    cmp("lit sat flag hold", 32'(s0), 32'd1);
    step(1, 0, 0, 0, 1, 4'd0);
    cmp("lit sat flag clr", 32'(s0), 32'd0);

    // Loads and clamp
    step(1, 1, 0, 0, 0, 4'b1100);
    cmp("lit load 1100 m9", 32'(b1), 32'd8);
    step(1, 1, 0, 0, 0, 4'b1000);
    cmp("lit clamp bin", 32'(b1), 32'd9);
    cmp("lit clamp err", 32'(l1), 32'd1);
    cmp("lit full load bin", 32'(b0), 32'd15);
    cmp("lit full load noerr", 32'(l0), 32'd0);
    step(1, 0, 0, 0, 0, 4'd0);
    cmp("lit clamp err clr", 32'(l1), 32'd0);

    // Load beats count
    step(1, 1, 1, 1, 0, 4'b0110);
    cmp("lit load+en bin", 32'(b0), 32'd4);
    cmp("lit load+en gray", 32'(g0), 32'd6);

    // Saturate at the top
    step(1, 1, 0, 0, 0, 4'b1000);
    step(1, 0, 1, 1, 1, 4'd0);
    cmp("lit sat top bin", 32'(b0), 32'd15);
    cmp("lit sat top flag", 32'(s0), 32'd1);
    cmp("lit sat top nowrap", 32'(w0), 32'd0);

    // Reset mid-count
    step(0, 0, 0, 0, 0, 4'd0);
    for (int i = 0; i < 7; i++) step(1, 0, 1, 1, 0, 4'd0);
    cmp("lit mid bin 7", 32'(b0), 32'd7);
    step(0, 0, 1, 1, 0, 4'd0);
    cmp("lit mid reset", 32'(b0), 32'd0);
    step(1, 0, 1, 1, 0, 4'd0);
    cmp("lit resume 1", 32'(b0), 32'd1);
    step(1, 0, 1, 1, 0, 4'd0);
    cmp("lit resume 2", 32'(b0), 32'd2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) >= 3), ($urandom_range(99) < 10), ($urandom_range(99) < 75),
           1'($urandom), ($urandom_range(99) < 40), 4'($urandom));
    end

`ifdef GRAY_CHECK_EN
    // Corrupt gray_out so the next count step is non-adjacent
    step(0, 0, 0, 0, 0, 4'd0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 0, 4'd0);
    #1;
    u0.gray_out = 4'b0000;
    force_g0 = 1'b1;
    @(negedge clk);
    cmp("lit gray_err set", 32'(e0), 32'd1);
    step(1, 0, 1, 1, 0, 4'd0);
    step(1, 0, 0, 0, 0, 4'd0);
    cmp("lit gray_err sticky", 32'(e0), 32'd1);
    step(0, 0, 0, 0, 0, 4'd0);
    cmp("lit gray_err reset", 32'(e0), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
